alu_result_fifo: RTL

//   Downstream stage of the 8-bit ALU. Captures each ALU result C and its flags
//   {OF,ZF,SF,PF} into a DEPTH-entry first-word-fall-through FIFO. Hands them to
//   the consumer over a valid/ready handshake. Also keeps a sticky overflow flag
//   and a saturating count of results dropped while the FIFO was full.

---
 rtl/alu_result_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO behind the 8-bit ALU: stores C plus {OF,ZF,SF,PF},
// hands entries out over valid/ready, tracks a sticky overflow and a saturating drop count.

module alu_result_fifo_cell #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage is deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           C,
  input  logic                       OF,
  input  logic                       ZF,
  input  logic                       SF,
  input  logic                       PF,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [3:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       sticky_of,
  input  logic                       clr_sticky,
  output logic [CNTW-1:0]            drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + 4;

  typedef struct packed {
    logic [3:0]       flags;
    logic [WIDTH-1:0] data;
  } entry_t;

  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [DEPTH-1:0][EW-1:0] mem_q;
  entry_t                   wr_ent, head;
  logic                     push, pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  // in_ready is ~full, so a pop while full cannot free a slot for this cycle's push.
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_ent.flags = {OF, ZF, SF, PF};
  assign wr_ent.data  = C;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_cell
      alu_result_fifo_cell #(.W(EW)) u_cell (
        .clk (clk),
        .we  (push && (wr_ptr == PW'(i))),
        .d   (wr_ent),
        .q   (mem_q[i])
      );
    end
  endgenerate

  assign head      = entry_t'(mem_q[rd_ptr]);
  assign out_data  = empty ? '0 : head.data;
  assign out_flags = empty ? '0 : head.flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sticky_of <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      // Set beats clear when both happen together.
      if (push && OF)      sticky_of <= 1'b1;
      else if (clr_sticky) sticky_of <= 1'b0;
      if (in_valid && full && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNTW'(1);
    end
  end
endmodule
